uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  Memory-mapped UART transmitter; bus responder on the CPU peripheral bus (addr/en/we/byte_sel/data_in/data_out).
//  CPU writes bytes into a small TX FIFO; a baud-rate FSM serialises them onto tx_out as 8N1 frames.
//  Sits beside leds/switches/digits/beep/keyboard in the IO space; status register allows polling.
// PARAMETERS
//  BASE_ADDR   32'hFFFFFD20  base of 3-word register window
//  FIFO_DEPTH  8             TX FIFO entries; power of 2, >=2
//  DIV_RESET   16'd434       reset baud divisor (50 MHz / 115200)
// PORTS
//  clk       in   1   system clock, rising edge
//  rst       in   1   asynchronous, active-high reset
//  addr      in   32  bus byte address
//  en        in   1   bus access strobe
//  we        in   1   1=write, 0=read
//  byte_sel  in   4   byte lanes of data_in valid for writes
//  data_in   in   32  write data
//  data_out  out  32  read data
//  tx_out    out  1   serial line, idle high
// BEHAVIOUR
//  Map: +0 DATA (W: push data_in[7:0] when byte_sel[0]; R: 0); +4 STATUS (R); +8 DIV (R/W, [15:0], lanes 0/1).
//  STATUS: [0] busy (FSM not IDLE), [1] full, [2] empty, [3] overflow (sticky), [7:4] fifo count, others 0.
//  Write STATUS with data_in[3]=1, byte_sel[0]=1 clears overflow; other STATUS bits ignored on write.
//  Access hits only when addr[31:4]==BASE_ADDR[31:4], addr[3:2]<3; misses ignored, data_out=0.
//  Writes take effect on the rising clk edge with en&&we; reads combinational: data_out valid while en&&!we&&hit, else 0.
//  Reset: tx_out=1, FIFO empty, overflow=0, DIV=DIV_RESET, FSM IDLE, data_out=0. Mid-frame reset aborts the frame and returns tx_out to 1 immediately.
//  FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE, or -> START directly if the FIFO is non-empty.
//  IDLE pops on the first edge with FIFO non-empty; tx_out=0 from that edge. Write at edge N -> start bit from edge N+1.
//  Each bit lasts max(DIV,1) clk cycles; DIV latched at frame start, so a DIV write mid-frame affects the next frame only.
//  Back-to-back frames: no idle gap; frame = 10*DIV cycles.
//  Push on full FIFO: byte dropped, overflow<=1, unless a pop happens the same edge (then accepted).
//  Simultaneous push+pop: both occur, count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  Count field saturates in [7:4]; if FIFO_DEPTH>15 it reports min(count,15).
// CONFIGURATION
//  UART_TX_PARITY_EN defined: an even-parity bit is inserted after D7 (state PARITY); frame = 11*DIV cycles;
//   STATUS[8]=1 reports the feature is present.
//  Undefined: 8N1 only, no PARITY state, STATUS[8]=0.
// STRUCTURE
//  Shared package (io_pkg): register offsets (DATA/STATUS/DIV), STATUS bit positions, FSM state encoding,
//   DIV_RESET default.
//  Sub-module sync_fifo (width 8, depth FIFO_DEPTH, push/pop/full/empty/count); FSM, bit counter, baud counter
//   and bus decode in uart_tx.
// TESTING
//  1 Reset: rst=1 mid-operation -> tx_out=1, STATUS read = 32'h00000004, DIV read = 434.
//  2 DIV=4, write DATA=8'h55 -> tx_out 0,1,0,1,0,1,0,1,0,1 each 4 clk, start bit at edge N+1, busy during 40 clk.
//  3 DIV=2, write 3 bytes A5,3C,FF back-to-back -> 3 contiguous frames with no idle, STATUS empty=1 afterwards.
//  4 Halt FSM via DIV=1000, write 10 bytes -> 1 popped, 8 stored, 9th accepted/dropped per timing, 10th dropped;
//    overflow=1; write STATUS bit3 -> overflow=0.
//  5 Read at unmapped addr 32'hFFFFFD2C and with en=0 -> data_out=0; write to DIV with byte_sel=4'b0001 changes only DIV[7:0].
//  6 UART_TX_PARITY_EN: DIV=4, byte 8'h07 -> parity bit 1, stop after 44 clk; without macro stop after 40 clk.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the IO-space UART transmitter: register offsets, STATUS bits, FSM encoding.
// UART_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package io_pkg;

   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DIV    = 2'd2;

   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 4;
   localparam int ST_PAR     = 8;

   localparam logic [15:0] DIV_RESET_DEF = 16'd434;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_e;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;
`endif

   // A divisor of zero still gives one clock per bit.
   function automatic logic [15:0] bit_len(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, programmable baud divisor and pollable STATUS.
// Define UART_TX_PARITY_EN to insert an even-parity bit after D7.
//
// state    | meaning
// S_IDLE   | line high, waiting for a FIFO entry
// S_START  | start bit (line low)
// S_DATA   | eight data bits, LSB first
// S_PARITY | even parity of the byte (UART_TX_PARITY_EN only)
// S_STOP   | stop bit (line high), chains into next frame if FIFO non-empty
module uart_tx
   import io_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFFFD20,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = DIV_RESET_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        en,
   input  logic        we,
   input  logic [3:0]  byte_sel,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        tx_out
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_e   state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [15:0] reload_q, reload_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic [15:0] div_q;
   logic        ovf_q;

   logic        hit, bus_wr, bus_rd, push, pop, tick;
   logic        fifo_full, fifo_empty;
   logic [7:0]  fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic [3:0]  cnt_sat;
   logic [31:0] status;
   logic        unused_bits;

   assign hit    = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'd3);
   assign bus_wr = en && we && hit;
   assign bus_rd = en && !we && hit;
   assign push   = bus_wr && (addr[3:2] == OFF_DATA) && byte_sel[0];
   assign tick   = (baud_q == 16'd0);
   assign unused_bits = ^{addr[1:0], byte_sel[3:2], data_in[31:16]};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (data_in[7:0]),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         reload_q <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         reload_q <= reload_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
      end
   end

   always_comb begin
      logic load;
      load     = 1'b0;
      pop      = 1'b0;
      state_d  = state_q;
      reload_d = reload_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_d    = par_q;
      baud_d   = baud_q;
      if (state_q != S_IDLE) baud_d = tick ? reload_q : baud_q - 16'd1;
      case (state_q)
         S_IDLE: load = !fifo_empty;
         S_START: if (tick) begin
            state_d = S_DATA;
            bit_d   = 3'd7;
         end
         S_DATA: if (tick) begin
            shift_d = shift_q >> 1;
            if (bit_q == 3'd0) begin
`ifdef UART_TX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end else begin
               bit_d = bit_q - 3'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: if (tick) state_d = S_STOP;
`endif
         S_STOP: if (tick) begin
            if (fifo_empty) state_d = S_IDLE;
            else            load    = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      // Divisor is sampled only here, so DIV writes mid-frame wait for the next frame.
      if (load) begin
         pop      = 1'b1;
         state_d  = S_START;
         shift_d  = fifo_rdata;
         par_d    = ^fifo_rdata;
         reload_d = bit_len(div_q) - 16'd1;
         baud_d   = bit_len(div_q) - 16'd1;
      end
   end

   always_comb begin
      case (state_q)
         S_START: tx_out = 1'b0;
         S_DATA:  tx_out = shift_q[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_out = par_q;
`endif
         default: tx_out = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= DIV_RESET;
         ovf_q <= 1'b0;
      end else begin
         if (bus_wr && (addr[3:2] == OFF_DIV)) begin
            if (byte_sel[0]) div_q[7:0]  <= data_in[7:0];
            if (byte_sel[1]) div_q[15:8] <= data_in[15:8];
         end
         if (push && fifo_full && !pop)
            ovf_q <= 1'b1;
         else if (bus_wr && (addr[3:2] == OFF_STATUS) && byte_sel[0] && data_in[3])
            ovf_q <= 1'b0;
      end
   end

   assign cnt_sat = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);

   always_comb begin
      status                          = '0;
      status[ST_BUSY]                 = (state_q != S_IDLE);
      status[ST_FULL]                 = fifo_full;
      status[ST_EMPTY]                = fifo_empty;
      status[ST_OVF]                  = ovf_q;
      status[ST_CNT_LSB+3:ST_CNT_LSB] = cnt_sat;
`ifdef UART_TX_PARITY_EN
      status[ST_PAR]                  = 1'b1;
`endif
   end

   always_comb begin
      data_out = '0;
      if (bus_rd) begin
         case (addr[3:2])
            OFF_STATUS: data_out = status;
            OFF_DIV:    data_out = {16'd0, div_q};
            default:    data_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: register-access vector table plus frame, back-to-back, overflow and reset sequences.
module tb_uart_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0, we = 1'b0;
   logic [31:0] addr = '0;
   logic [3:0]  byte_sel = '0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   logic        tx_out;

   int n_vec = 0;
   int n_err = 0;

`ifdef UART_TX_PARITY_EN
   localparam logic [31:0] PF = 32'h100;
   localparam int NBITS = 11;
`else
   localparam logic [31:0] PF = 32'h000;
   localparam int NBITS = 10;
`endif
   localparam logic [31:0] A_DATA = 32'hFFFFFD20;
   localparam logic [31:0] A_STAT = 32'hFFFFFD24;
   localparam logic [31:0] A_DIV  = 32'hFFFFFD28;

   uart_tx dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .en       (en),
      .we       (we),
      .byte_sel (byte_sel),
      .data_in  (data_in),
      .data_out (data_out),
      .tx_out   (tx_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          en;
      bit          we;
      logic [31:0] addr;
      logic [3:0]  bs;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [3:0] bs, input logic [31:0] d);
      en = 1'b1; we = 1'b1; addr = a; byte_sel = bs; data_in = d;
      @(posedge clk);
      #1;
      en = 1'b0; we = 1'b0; byte_sel = '0;
   endtask

   task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
      en = 1'b1; we = 1'b0; addr = a;
      #1;
      check(name, data_out, exp);
      en = 1'b0;
   endtask

   task automatic expect_frame(input logic [7:0] b, input int div, input bit chk_busy);
      logic [10:0] bits;
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
      bits[9] = ^b;
`endif
      for (int i = 0; i < NBITS; i++) begin
         for (int c = 0; c < div; c++) begin
            @(negedge clk);
            check($sformatf("frame_%02h_bit%0d_cyc%0d", b, i, c), {31'd0, tx_out}, {31'd0, bits[i]});
            if (chk_busy) begin
               en = 1'b1; we = 1'b0; addr = A_STAT;
               #1;
               check($sformatf("busy_%02h_bit%0d", b, i), {31'd0, data_out[0]}, 32'd1);
               en = 1'b0;
            end
         end
      end
   endtask

   task automatic idle_lead;
      repeat (2) begin
         @(negedge clk);
         check("idle_before_start", {31'd0, tx_out}, 32'd1);
      end
   endtask

   initial begin
      vt.push_back('{"rd_status_rst", 1, 0, A_STAT, 4'h0, 32'h0, 32'h4 | PF});
      vt.push_back('{"rd_div_rst",    1, 0, A_DIV,  4'h0, 32'h0, 32'h1B2});
      vt.push_back('{"rd_data",       1, 0, A_DATA, 4'h0, 32'h0, 32'h0});
      vt.push_back('{"rd_unmapped",   1, 0, 32'hFFFFFD2C, 4'h0, 32'h0, 32'h0});
      vt.push_back('{"rd_en_low",     0, 0, A_STAT, 4'h0, 32'h0, 32'h0});
      vt.push_back('{"rd_other_blk",  1, 0, 32'hFFFFFD34, 4'h0, 32'h0, 32'h0});
      vt.push_back('{"wr_data_lane1", 1, 1, A_DATA, 4'b0010, 32'h11, 32'h0});
      vt.push_back('{"rd_status_np",  1, 0, A_STAT, 4'h0, 32'h0, 32'h4 | PF});
      vt.push_back('{"wr_div_lane0",  1, 1, A_DIV,  4'b0001, 32'hABCD1234, 32'h0});
      vt.push_back('{"rd_div_l0",     1, 0, A_DIV,  4'h0, 32'h0, 32'h0134});
      vt.push_back('{"wr_div_lane1",  1, 1, A_DIV,  4'b0010, 32'h00005600, 32'h0});
      vt.push_back('{"rd_div_l1",     1, 0, A_DIV,  4'h0, 32'h0, 32'h5634});
      vt.push_back('{"wr_div_en_low", 0, 1, A_DIV,  4'b0011, 32'h9, 32'h0});
      vt.push_back('{"rd_div_keep",   1, 0, A_DIV,  4'h0, 32'h0, 32'h5634});
      vt.push_back('{"wr_unmapped",   1, 1, 32'hFFFFFD2C, 4'hF, 32'h7, 32'h0});
      vt.push_back('{"rd_div_keep2",  1, 0, A_DIV,  4'h0, 32'h0, 32'h5634});
      vt.push_back('{"wr_div_4",      1, 1, A_DIV,  4'hF, 32'hFFFF0004, 32'h0});
      vt.push_back('{"rd_div_4",      1, 0, A_DIV,  4'h0, 32'h0, 32'h4});

      repeat (3) @(posedge clk);
      #1;
      check("tx_in_reset", {31'd0, tx_out}, 32'd1);
      rst = 1'b0;

      foreach (vt[i]) begin
         en = vt[i].en; we = vt[i].we; addr = vt[i].addr;
         byte_sel = vt[i].bs; data_in = vt[i].wd;
         #1;
         check(vt[i].name, data_out, vt[i].exp);
         @(posedge clk);
         #1;
         en = 1'b0; we = 1'b0; byte_sel = '0;
      end

      // Single frame at DIV=4
      fork
         bus_write(A_DATA, 4'b0001, 32'h55);
         begin idle_lead(); expect_frame(8'h55, 4, 1'b1); end
      join
      @(negedge clk);
      check("tx_idle_after_55", {31'd0, tx_out}, 32'd1);
      read_check("status_after_55", A_STAT, 32'h4 | PF);

      // Three contiguous frames at DIV=2
      bus_write(A_DIV, 4'b0011, 32'd2);
      fork
         begin
            bus_write(A_DATA, 4'b0001, 32'hA5);
            bus_write(A_DATA, 4'b0001, 32'h3C);
            bus_write(A_DATA, 4'b0001, 32'hFF);
         end
         begin
            idle_lead();
            expect_frame(8'hA5, 2, 1'b0);
            expect_frame(8'h3C, 2, 1'b0);
            expect_frame(8'hFF, 2, 1'b0);
         end
      join
      @(negedge clk);
      check("tx_idle_after_b2b", {31'd0, tx_out}, 32'd1);
      read_check("status_after_b2b", A_STAT, 32'h4 | PF);

      // FSM stalled in the start bit while the FIFO fills and overflows
      bus_write(A_DIV, 4'b0011, 32'd1000);
      for (int i = 0; i < 10; i++) bus_write(A_DATA, 4'b0001, 32'h10 + i);
      @(negedge clk);
      check("tx_start_stall", {31'd0, tx_out}, 32'd0);
      read_check("status_full_ovf", A_STAT, 32'h8B | PF);
      bus_write(A_STAT, 4'b0001, 32'h0);
      read_check("status_ovf_kept", A_STAT, 32'h8B | PF);
      bus_write(A_STAT, 4'b0001, 32'h8);
      read_check("status_ovf_clr", A_STAT, 32'h83 | PF);

      // Reset in the middle of a frame
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("tx_async_reset", {31'd0, tx_out}, 32'd1);
      read_check("status_in_reset", A_STAT, 32'h4 | PF);
      read_check("div_in_reset", A_DIV, 32'h1B2);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("tx_idle_post_reset", {31'd0, tx_out}, 32'd1);
      end
      read_check("status_post_reset", A_STAT, 32'h4 | PF);

      // Frame length with/without parity for byte 0x07
      @(posedge clk);
      #1;
      bus_write(A_DIV, 4'b0011, 32'd4);
      fork
         bus_write(A_DATA, 4'b0001, 32'h07);
         begin idle_lead(); expect_frame(8'h07, 4, 1'b1); end
      join
      @(negedge clk);
      check("tx_idle_after_07", {31'd0, tx_out}, 32'd1);
      read_check("status_after_07", A_STAT, 32'h4 | PF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
